// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control sequencer for an RV32I datapath. It owns the program
// counter, the instruction register, a retired-instruction counter and a
// six-state FSM (FETCH, DECODE, EXEC, MEM, WB, TRAP). Instruction and data
// memory accesses are handshaked and may take any number of wait states,
// bounded by an optional timeout.
//
// Handshake: a request (imem_req / dmem_req) is a Moore output decoded from
// the current state. The matching ready is sampled only on a rising edge where
// the request is 1; a ready seen while the request is 0 is ignored.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   imem_req/addr     instruction fetch request and byte address (= pc)
//   imem_rdata/ready  fetched instruction and its valid strobe
//   dmem_req/we       data access request, 1 = store
//   dmem_ready        data access complete
//   imm, alu_zero     immediate from the imm generator, ALU zero flag
//   ir, pc            instruction register, program counter
//   ctrl_*            datapath control (alu_op, alu_src, reg_w, mem_to_reg)
//   state             current FSM state code
//   halt, err_code    sticky stop flag and trap cause
//   retired           count of retired instructions (wraps mod 2^32)
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int INST_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  imem_ready,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ready,
    input  logic [31:0]           imm,
    input  logic                  alu_zero,
    output logic [INST_WIDTH-1:0] ir,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [1:0]            ctrl_alu_op,
    output logic                  ctrl_alu_src,
    output logic                  ctrl_reg_w,
    output logic                  ctrl_mem_to_reg,
    output logic [2:0]            state,
    output logic                  halt,
    output logic [1:0]            err_code,
    output logic [31:0]           retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R       = 3'd0,
        C_I       = 3'd1,
        C_LOAD    = 3'd2,
        C_STORE   = 3'd3,
        C_BRANCH  = 3'd4,
        C_ILLEGAL = 3'd5
    } class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_MISALIGN = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Wait counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INST_WIDTH-1:0] ir_q, ir_d;
    logic [31:0]           retired_q, retired_d;
    logic                  halt_q, halt_d;
    logic [1:0]            err_q, err_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [1:0]            alu_op_q, alu_op_d;
    logic                  alu_src_q, alu_src_d;
    logic                  reg_w_q, reg_w_d;
    logic                  m2r_q, m2r_d;

    class_t                op_class;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  timeout_hit;
    logic                  unused_imm;

    // Only the low ADDR_WIDTH bits of the immediate affect the target.
    assign unused_imm    = ^imm;
    assign pc_plus4      = pc_q + ADDR_WIDTH'(4);
    assign branch_target = pc_q + imm[ADDR_WIDTH-1:0];
    // Ready in the same cycle as the limit wins, so this is only acted on
    // when ready is low.
    assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (wait_q == WAIT_MAX);

    // Instruction class decoded from the held instruction register.
    always_comb begin
        op_class = C_ILLEGAL;
        case (ir_q[6:0])
            OP_R:      op_class = C_R;
            OP_I:      op_class = C_I;
            OP_LOAD:   op_class = C_LOAD;
            OP_STORE:  op_class = C_STORE;
            OP_BRANCH: op_class = C_BRANCH;
            default:   op_class = C_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        halt_d    = halt_q;
        err_d     = err_q;
        wait_d    = wait_q;
        alu_op_d  = alu_op_q;
        alu_src_d = alu_src_q;
        reg_w_d   = 1'b0;
        m2r_d     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    err_d   = ERR_TIMEOUT;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                // Control values are registered here so they are visible
                // from the first EXEC cycle on.
                case (op_class)
                    C_R: begin
                        alu_op_d  = ALU_FUNCT;
                        alu_src_d = 1'b0;
                        state_d   = S_EXEC;
                    end
                    C_I: begin
                        alu_op_d  = ALU_FUNCT;
                        alu_src_d = 1'b1;
                        state_d   = S_EXEC;
                    end
                    C_LOAD, C_STORE: begin
                        alu_op_d  = ALU_ADD;
                        alu_src_d = 1'b1;
                        state_d   = S_EXEC;
                    end
                    C_BRANCH: begin
                        alu_op_d  = ALU_SUB;
                        alu_src_d = 1'b0;
                        state_d   = S_EXEC;
                    end
                    default: begin
                        state_d = S_TRAP;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                case (op_class)
                    C_R, C_I: begin
                        state_d = S_WB;
                        reg_w_d = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        state_d = S_MEM;
                    end
                    default: begin
                        // Only a taken target can be misaligned; pc+4 keeps
                        // the alignment of pc.
                        if (alu_zero && (branch_target[1:0] != 2'b00)) begin
                            state_d = S_TRAP;
                            err_d   = ERR_MISALIGN;
                        end else begin
                            pc_d      = alu_zero ? branch_target : pc_plus4;
                            retired_d = retired_q + 32'd1;
                            state_d   = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (op_class == C_STORE) begin
                        pc_d      = pc_plus4;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                        reg_w_d = 1'b1;
                        m2r_d   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    err_d   = ERR_TIMEOUT;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                pc_d      = pc_plus4;
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                // Unused codes 6 and 7.
                state_d = S_TRAP;
                err_d   = ERR_ILLEGAL;
            end
        endcase

        // Wait counter restarts whenever a new request phase begins.
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
            wait_d = '0;
        end

        // Control outputs are only live from EXEC through WB.
        if ((state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_TRAP)) begin
            alu_op_d  = 2'b00;
            alu_src_d = 1'b0;
            reg_w_d   = 1'b0;
            m2r_d     = 1'b0;
        end

        if (state_d == S_TRAP) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            retired_q <= '0;
            halt_q    <= 1'b0;
            err_q     <= ERR_NONE;
            wait_q    <= '0;
            alu_op_q  <= 2'b00;
            alu_src_q <= 1'b0;
            reg_w_q   <= 1'b0;
            m2r_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            reg_w_q   <= reg_w_d;
            m2r_q     <= m2r_d;
        end
    end

    // Requests are decoded from state and forced low while reset is held.
    assign imem_req        = rst & (state_q == S_FETCH);
    assign dmem_req        = rst & (state_q == S_MEM);
    assign dmem_we         = rst & (state_q == S_MEM) & (op_class == C_STORE);
    assign imem_addr       = pc_q;
    assign pc              = pc_q;
    assign ir              = ir_q;
    assign ctrl_alu_op     = alu_op_q;
    assign ctrl_alu_src    = alu_src_q;
    assign ctrl_reg_w      = reg_w_q;
    assign ctrl_mem_to_reg = m2r_q;
    assign state           = state_q;
    assign halt            = halt_q;
    assign err_code        = err_q;
    assign retired         = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Self-checking bench for multicycle_sequencer. Each instruction is run from
// FETCH to the next FETCH (or to TRAP) with bench-modelled memories that answer
// after a chosen number of wait cycles. A reference model computes latency,
// next pc, trap cause and control behaviour from the instruction class.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;
  localparam int AW = 10;
  localparam int TO = 15;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00508093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          imem_ready = 1'b0;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ready = 1'b0;
  logic [31:0]   imm = '0;
  logic          alu_zero = 1'b0;
  logic [31:0]   ir;
  logic [AW-1:0] pc;
  logic [1:0]    ctrl_alu_op;
  logic          ctrl_alu_src;
  logic          ctrl_reg_w;
  logic          ctrl_mem_to_reg;
  logic [2:0]    state;
  logic          halt;
  logic [1:0]    err_code;
  logic [31:0]   retired;

  int errors = 0;
  int checks = 0;
  int exp_pc = 0;
  logic [31:0] exp_retired = '0;
  logic [AW-1:0] exp_q[$];

  multicycle_sequencer #(
    .INST_WIDTH(32), .ADDR_WIDTH(AW), .RESET_PC(0), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .imm(imm), .alu_zero(alu_zero),
    .ir(ir), .pc(pc),
    .ctrl_alu_op(ctrl_alu_op), .ctrl_alu_src(ctrl_alu_src),
    .ctrl_reg_w(ctrl_reg_w), .ctrl_mem_to_reg(ctrl_mem_to_reg),
    .state(state), .halt(halt), .err_code(err_code), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    alu_zero = 1'b0;
    imm = '0;
    imem_rdata = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    exp_pc = 0;
    exp_retired = '0;
    exp_q.delete();
  endtask

  // Runs one instruction; iwait/dwait are the ready=0 cycles before ready.
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] imm_v,
                           input logic zero_v, input int iwait, input int dwait);
    logic [6:0] op;
    int cyc, fetch_n, mem_n, regw_n, regw_cyc, imm_s, tgt;
    int e_cyc, e_fetch, e_mem, e_regw, e_newpc;
    logic e_trap, e_m2r, e_we, e_src, e_exec, e_memp, left, done;
    logic [1:0] e_err, e_op, exec_op;
    logic m2r_seen, we_seen, exec_src, hold_bad, idle_bad, post_bad;
    logic [AW-1:0] pc_exp;

    // Reference model: outcome from instruction class and wait counts.
    op = instr[6:0];
    imm_s = imm_v;
    e_trap = 0; e_err = 2'b00; e_regw = 0; e_m2r = 0; e_we = 0;
    e_exec = 0; e_memp = 0; e_op = 2'b00; e_src = 0; e_mem = 0;
    e_newpc = exp_pc;
    e_fetch = (iwait > TO) ? TO + 1 : iwait + 1;
    e_cyc = e_fetch;
    if (iwait > TO) begin
      e_trap = 1; e_err = 2'b10;
    end else begin
      case (op)
        7'b0110011, 7'b0010011: begin
          e_exec = 1; e_op = 2'b10; e_src = (op == 7'b0010011);
          e_cyc = e_fetch + 3; e_regw = 1; e_newpc = (exp_pc + 4) % (1 << AW);
        end
        7'b0000011, 7'b0100011: begin
          e_exec = 1; e_memp = 1; e_op = 2'b00; e_src = 1;
          e_we = (op == 7'b0100011);
          e_mem = (dwait > TO) ? TO + 1 : dwait + 1;
          if (dwait > TO) begin
            e_trap = 1; e_err = 2'b10; e_cyc = e_fetch + 2 + e_mem;
          end else begin
            e_newpc = (exp_pc + 4) % (1 << AW);
            e_cyc = e_fetch + 2 + e_mem + (e_we ? 0 : 1);
            e_regw = e_we ? 0 : 1;
            e_m2r = !e_we;
          end
        end
        7'b1100011: begin
          e_exec = 1; e_op = 2'b01; e_src = 0;
          e_cyc = e_fetch + 2;
          tgt = (exp_pc + imm_s) & ((1 << AW) - 1);
          if (zero_v && (tgt % 4 != 0)) begin
            e_trap = 1; e_err = 2'b11;
          end else begin
            e_newpc = zero_v ? tgt : (exp_pc + 4) % (1 << AW);
          end
        end
        default: begin
          e_trap = 1; e_err = 2'b01; e_cyc = e_fetch + 1;
        end
      endcase
    end
    if (!e_trap) begin
      exp_pc = e_newpc;
      exp_retired = exp_retired + 32'd1;
    end
    exp_q.push_back(exp_pc[AW-1:0]);

    // Drive and observe.
    imem_rdata = instr; imm = imm_v; alu_zero = zero_v;
    cyc = 0; fetch_n = 0; mem_n = 0; regw_n = 0; regw_cyc = -1;
    m2r_seen = 0; we_seen = 0; exec_op = 2'b00; exec_src = 0;
    hold_bad = 0; idle_bad = 0; left = 0; done = 0;
    while (!done) begin
      imem_ready = imem_req && (fetch_n == iwait);
      if (imem_req) fetch_n++;
      dmem_ready = dmem_req && (mem_n == dwait);
      if (dmem_req) begin
        mem_n++;
        if (dmem_we) we_seen = 1;
      end
      if (ctrl_reg_w) begin
        regw_n++; regw_cyc = cyc; m2r_seen = ctrl_mem_to_reg;
      end
      if (state == 3'd2) begin
        exec_op = ctrl_alu_op; exec_src = ctrl_alu_src;
      end else if (state == 3'd3 || state == 3'd4) begin
        if (ctrl_alu_op !== exec_op || ctrl_alu_src !== exec_src) hold_bad = 1;
      end else if (ctrl_alu_op !== 2'b00 || ctrl_alu_src !== 1'b0 ||
                   ctrl_reg_w !== 1'b0 || ctrl_mem_to_reg !== 1'b0) begin
        idle_bad = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (state != 3'd0) left = 1;
      if ((left && state == 3'd0) || halt === 1'b1 || cyc >= 100) done = 1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    checks++; if (cyc !== e_cyc) begin errors++;
      $display("FAIL latency op=%b: got %0d cycles expected %0d", op, cyc, e_cyc); end
    checks++; if (halt !== e_trap) begin errors++;
      $display("FAIL halt op=%b: got %b expected %b", op, halt, e_trap); end
    checks++; if (err_code !== e_err) begin errors++;
      $display("FAIL err_code op=%b: got %b expected %b", op, err_code, e_err); end
    pc_exp = exp_q.pop_front();
    checks++; if (pc !== pc_exp) begin errors++;
      $display("FAIL pc op=%b: got %0d expected %0d", op, pc, pc_exp); end
    checks++; if (retired !== exp_retired) begin errors++;
      $display("FAIL retired op=%b: got %0d expected %0d", op, retired, exp_retired); end
    checks++; if (fetch_n !== e_fetch) begin errors++;
      $display("FAIL imem_req cycles: got %0d expected %0d", fetch_n, e_fetch); end
    checks++; if (hold_bad !== 1'b0 || idle_bad !== 1'b0) begin errors++;
      $display("FAIL ctrl hold/idle: got hold_bad=%b idle_bad=%b expected 0 0", hold_bad, idle_bad); end
    if (e_exec) begin
      checks++; if (exec_op !== e_op || exec_src !== e_src) begin errors++;
        $display("FAIL exec ctrl op=%b: got alu_op=%b src=%b expected %b %b", op, exec_op, exec_src, e_op, e_src); end
    end
    if (e_memp) begin
      checks++; if (mem_n !== e_mem || we_seen !== e_we) begin errors++;
        $display("FAIL dmem: got cycles=%0d we=%b expected %0d %b", mem_n, we_seen, e_mem, e_we); end
    end
    if (!e_trap) begin
      checks++; if (regw_n !== e_regw) begin errors++;
        $display("FAIL reg_w count: got %0d expected %0d", regw_n, e_regw); end
      if (e_regw == 1) begin
        checks++; if (regw_cyc !== e_cyc - 1 || m2r_seen !== e_m2r) begin errors++;
          $display("FAIL reg_w timing: got cycle=%0d m2r=%b expected %0d %b", regw_cyc, m2r_seen, e_cyc - 1, e_m2r); end
      end
    end else begin
      post_bad = 0;
      for (int k = 0; k < 3; k++) begin
        if (imem_req !== 1'b0 || dmem_req !== 1'b0 || ctrl_reg_w !== 1'b0 ||
            ctrl_alu_op !== 2'b00 || state !== 3'd5 || halt !== 1'b1) post_bad = 1;
        @(posedge clk);
        #1;
      end
      checks++; if (post_bad !== 1'b0 || err_code !== e_err) begin errors++;
        $display("FAIL trap hold: got bad=%b err=%b expected 0 %b", post_bad, err_code, e_err); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (state !== 3'd0 || pc !== '0 || ir !== '0) begin errors++;
      $display("FAIL reset regs: got state=%0d pc=%0d ir=%h expected 0 0 0", state, pc, ir); end
    checks++; if (retired !== '0 || halt !== 1'b0 || err_code !== 2'b00) begin errors++;
      $display("FAIL reset status: got retired=%0d halt=%b err=%b expected 0 0 00", retired, halt, err_code); end
    checks++; if ({imem_req, dmem_req, dmem_we, ctrl_alu_op, ctrl_alu_src, ctrl_reg_w, ctrl_mem_to_reg} !== 8'b0) begin errors++;
      $display("FAIL reset outputs: got imem_req=%b dmem_req=%b ctrl=%b%b%b%b expected all 0", imem_req, dmem_req,
               ctrl_alu_op, ctrl_alu_src, ctrl_reg_w, ctrl_mem_to_reg); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== '0) begin errors++;
      $display("FAIL reset release: got imem_req=%b addr=%0d expected 1 0", imem_req, imem_addr); end
    exp_pc = 0;
    exp_retired = '0;
  endtask

  task automatic test_rtype;
    run_instr(I_ADD, 32'd0, 1'b0, 0, 0);
    run_instr(I_ADDI, 32'd5, 1'b0, 2, 0);
  endtask

  task automatic test_load_wait;
    do_reset;
    run_instr(I_LW, 32'd0, 1'b0, 0, 3);
    run_instr(I_SW, 32'd0, 1'b0, 1, 2);
    run_instr(I_LW, 32'd0, 1'b0, 0, 0);
  endtask

  task automatic test_branch;
    do_reset;
    run_instr(I_BEQ, 32'd16, 1'b1, 0, 0);
    run_instr(I_BEQ, -32'sd8, 1'b1, 0, 0);
    run_instr(I_BEQ, 32'd8, 1'b1, 0, 0);
    run_instr(I_BEQ, 32'd100, 1'b0, 0, 0);
    run_instr(I_BEQ, -32'sd4, 1'b1, 0, 0);
    run_instr(I_BEQ, 32'd6, 1'b1, 0, 0);
  endtask

  task automatic test_illegal;
    do_reset;
    run_instr(I_BAD, 32'd0, 1'b0, 0, 0);
  endtask

  task automatic test_timeout;
    do_reset;
    run_instr(I_ADD, 32'd0, 1'b0, 16, 0);
    do_reset;
    run_instr(I_ADD, 32'd0, 1'b0, 15, 0);
    run_instr(I_SW, 32'd0, 1'b0, 0, 15);
    run_instr(I_LW, 32'd0, 1'b0, 0, 16);
  endtask

  task automatic test_wrap;
    do_reset;
    run_instr(I_BEQ, 32'd1020, 1'b1, 0, 0);
    run_instr(I_ADD, 32'd0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_mem;
    int n;
    do_reset;
    run_instr(I_ADD, 32'd0, 1'b0, 0, 0);
    imem_rdata = I_LW;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    n = 0;
    while (state !== 3'd3 && n < 20) begin
      @(posedge clk);
      #1;
      imem_ready = 1'b0;
      n++;
    end
    checks++; if (state !== 3'd3 || dmem_req !== 1'b1) begin errors++;
      $display("FAIL reach MEM: got state=%0d dmem_req=%b expected 3 1", state, dmem_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0 || pc !== '0 || retired !== '0 || state !== 3'd0) begin errors++;
      $display("FAIL reset mid-MEM: got dmem_req=%b imem_req=%b pc=%0d retired=%0d state=%0d expected 0 0 0 0 0",
               dmem_req, imem_req, pc, retired, state); end
    dmem_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (state !== 3'd0 || pc !== '0 || retired !== '0 || dmem_req !== 1'b0) begin errors++;
      $display("FAIL stale dmem_ready: got state=%0d pc=%0d retired=%0d expected 0 0 0", state, pc, retired); end
    do_reset;
  endtask

  task automatic test_random;
    logic [31:0] r, instr, imm_v;
    logic [6:0] op;
    logic zero_v;
    int sel, iw, dw;
    do_reset;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    op = 7'b0110011;
        2, 3:    op = 7'b0010011;
        4, 5:    op = 7'b0000011;
        6, 7:    op = 7'b0100011;
        8, 9:    op = 7'b1100011;
        10:      op = 7'b0110111;
        default: op = 7'b1111111;
      endcase
      r = $urandom();
      instr = {r[31:7], op};
      iw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      zero_v = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) imm_v = 32'($urandom_range(0, 3) * 4 + 2);
      else imm_v = 32'((int'($urandom_range(0, 16)) - 8) * 4);
      run_instr(instr, imm_v, zero_v, iw, dw);
      if (halt === 1'b1) do_reset;
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_load_wait;
    test_branch;
    test_illegal;
    test_timeout;
    test_wrap;
    test_reset_mid_mem;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
